// File: rtl/des_feistel_mix.sv
// ============================================================================
//  Module      : des_feistel_mix
//  Description : DES round-data controller. Holds the L/R halves of one
//                post-IP block, issues R to the expansion/key-XOR stage once
//                per round, applies the P permutation to the returned S-box
//                word, XORs it into L and swaps the halves. After the last
//                round the pre-output block {R16, L16} is presented.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_ROUNDS     number of Feistel rounds (1..16)
//    TIMEOUT_CYC    WAIT watchdog limit in cycles (timeout build only)
//  Optional feature macro
//    DES_FEISTEL_TIMEOUT_EN  adds a WAIT watchdog and the err_out port
//  Ports
//    clk_in         clock, rising edge
//    rst_in         asynchronous active-high reset
//    blk_in         post-IP block, [63:32]=L0, [31:0]=R0
//    blk_in_valid   blk_in qualifier
//    blk_in_ready   high while idle; accept = valid & ready
//    r_out          current R half to the expansion/key-XOR stage
//    r_out_valid    one-cycle pulse per round request
//    round_idx_out  round index, selects the subkey
//    scomp_in       S-box output word from des_scomp
//    scomp_in_valid single-cycle qualifier for scomp_in
//    blk_out        pre-output block {R16, L16}, held until the next block
//    blk_out_valid  one-cycle pulse when blk_out is updated
//    err_out        watchdog timeout pulse (timeout build only)
// ============================================================================
`default_nettype none

module des_feistel_mix #(
  parameter int NUM_ROUNDS  = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] blk_in,
  input  logic        blk_in_valid,
  output logic        blk_in_ready,
  output logic [31:0] r_out,
  output logic        r_out_valid,
  output logic [3:0]  round_idx_out,
  input  logic [31:0] scomp_in,
  input  logic        scomp_in_valid,
  output logic [63:0] blk_out,
  output logic        blk_out_valid
`ifdef DES_FEISTEL_TIMEOUT_EN
  ,
  output logic        err_out
`endif
);

  // Elaboration-time guard on the configuration.
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 16 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("des_feistel_mix: NUM_ROUNDS must be 1..16 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS - 1);

  // P permutation, DES numbering: output bit i (1 = MSB) takes input bit P[i].
  localparam int c_p_tab [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [3:0]  round_q, round_d;
  logic [63:0] blk_out_q, blk_out_d;
  logic [31:0] p_scomp;
  logic [31:0] f_xor_l;

  for (genvar i = 0; i < 32; i++) begin : g_perm
    assign p_scomp[31 - i] = scomp_in[32 - c_p_tab[i]];
  end

  assign f_xor_l = l_q ^ p_scomp;

`ifdef DES_FEISTEL_TIMEOUT_EN
  localparam int              c_cnt_w     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    r_d       = r_q;
    round_d   = round_q;
    blk_out_d = blk_out_q;
`ifdef DES_FEISTEL_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (blk_in_valid) begin
          l_d     = blk_in[63:32];
          r_d     = blk_in[31:0];
          round_d = 4'd0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef DES_FEISTEL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      ST_WAIT: begin
        if (scomp_in_valid) begin
          l_d = r_q;
          r_d = f_xor_l;
          if (round_q == c_last_round) begin
            // Captured with the last swap undone: {R16, L16}.
            blk_out_d = {f_xor_l, r_q};
            state_d   = ST_DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = ST_ISSUE;
          end
        end
`ifdef DES_FEISTEL_TIMEOUT_EN
        else if (cnt_q == c_cnt_last) begin
          // Abort the block; blk_out keeps its previous contents.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      l_q       <= '0;
      r_q       <= '0;
      round_q   <= '0;
      blk_out_q <= '0;
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      r_q       <= r_d;
      round_q   <= round_d;
      blk_out_q <= blk_out_d;
    end
  end

`ifdef DES_FEISTEL_TIMEOUT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign blk_in_ready  = (state_q == ST_IDLE);
  assign r_out         = r_q;
  assign r_out_valid   = (state_q == ST_ISSUE);
  assign round_idx_out = round_q;
  assign blk_out       = blk_out_q;
  assign blk_out_valid = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_des_feistel_mix.sv
// ============================================================================
//  Module      : tb_des_feistel_mix
//  Description : Directed self-checking bench for des_feistel_mix. Upstream
//                expansion/key-XOR and S-box stages are modelled here from the
//                DES tables with a random 0..5 cycle response delay.
//                Timeout checks are compiled only with DES_FEISTEL_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_feistel_mix;

  localparam int         NUM_ROUNDS  = 16;
  localparam int         TIMEOUT_CYC = 64;
  localparam logic [63:0] c_post_ip  = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] c_pre_out  = 64'h0A4CD99543423234;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [63:0] blk_in;
  logic        blk_in_valid;
  logic        blk_in_ready;
  logic [31:0] r_out;
  logic        r_out_valid;
  logic [3:0]  round_idx_out;
  logic [31:0] scomp_in;
  logic        scomp_in_valid;
  logic [63:0] blk_out;
  logic        blk_out_valid;
`ifdef DES_FEISTEL_TIMEOUT_EN
  logic        err_out;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  des_feistel_mix #(
    .NUM_ROUNDS  (NUM_ROUNDS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .blk_in         (blk_in),
    .blk_in_valid   (blk_in_valid),
    .blk_in_ready   (blk_in_ready),
    .r_out          (r_out),
    .r_out_valid    (r_out_valid),
    .round_idx_out  (round_idx_out),
    .scomp_in       (scomp_in),
    .scomp_in_valid (scomp_in_valid),
    .blk_out        (blk_out),
    .blk_out_valid  (blk_out_valid)
`ifdef DES_FEISTEL_TIMEOUT_EN
    ,
    .err_out        (err_out)
`endif
  );

  // ---------------------------------------------------------------- DES tables
  int pc1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                   10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                   63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  int pc2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                   23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                   41,52,31,37,47,55,30,40,51,45,33,48,
                   44,49,39,56,34,53,46,42,50,36,29,32};
  int key_shift [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sbox [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  logic [47:0] subkey [16];

  // Key schedule for key 133457799BBCDFF1.
  task automatic build_subkeys();
    logic [63:0] key;
    logic [55:0] cd;
    logic [27:0] c, d;
    key = 64'h133457799BBCDFF1;
    for (int j = 0; j < 56; j++) cd[55-j] = key[64-pc1[j]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < key_shift[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) subkey[i][47-j] = cd[56-pc2[j]];
    end
  endtask

  // Expansion, key XOR and S-boxes: what des_scomp returns for R.
  function automatic logic [31:0] scomp_model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [5:0]  six;
    logic [31:0] o;
    int          src;
    for (int b = 0; b < 8; b++) begin
      for (int m = 0; m < 6; m++) begin
        src = 4*b + m;
        if (src == 0)  src = 32;
        if (src == 33) src = 1;
        x[47-(6*b+m)] = r[32-src];
      end
    end
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      o[31-4*b -: 4] = 4'(sbox[b*64 + {26'd0, six[5], six[0]}*16 + {28'd0, six[4:1]}]);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
    tick();
  endtask

  // Run one block through all rounds with the upstream model answering.
  // abort_rnd >= 0 asserts reset while waiting in that round.
  task automatic run_block(input logic [63:0] blk, input int abort_rnd, input string tag);
    int          guard, n_issue, dly;
    logic        done;
    logic [3:0]  rnd;
    logic [31:0] s;
    blk_in       = blk;
    blk_in_valid = 1'b1;
    tick();
    blk_in_valid = 1'b0;
    guard   = 0;
    n_issue = 0;
    done    = 1'b0;
    while (!done && guard < 2000) begin
      if (blk_out_valid) begin
        done = 1'b1;
      end else if (r_out_valid) begin
        n_issue++;
        rnd = round_idx_out;
        s   = scomp_model(r_out, subkey[rnd]);
        tick();
        guard++;
        if (int'(rnd) == abort_rnd) begin
          rst_in = 1'b1;
          #1;
          check_val({tag, "_rst_rvalid"}, 64'(r_out_valid), 64'd0);
          check_val({tag, "_rst_ready"},  64'(blk_in_ready), 64'd1);
          check_val({tag, "_rst_r"},      64'(r_out), 64'd0);
          check_val({tag, "_rst_round"},  64'(round_idx_out), 64'd0);
          check_val({tag, "_rst_blkout"}, blk_out, 64'd0);
          rst_in = 1'b0;
          tick();
          check_val({tag, "_post_rst_bvalid"}, 64'(blk_out_valid), 64'd0);
          return;
        end
        dly = $urandom_range(0, 5);
        repeat (dly) begin
          tick();
          guard++;
        end
        scomp_in       = s;
        scomp_in_valid = 1'b1;
        tick();
        guard++;
        scomp_in_valid = 1'b0;
      end else begin
        tick();
        guard++;
      end
    end
    check_val({tag, "_done_seen"}, 64'(done), 64'd1);
    check_val({tag, "_issues"},    64'(n_issue), 64'(NUM_ROUNDS));
    check_val({tag, "_blk_out"},   blk_out, c_pre_out);
    tick();
    check_val({tag, "_bvalid_pulse"}, 64'(blk_out_valid), 64'd0);
    check_val({tag, "_ready_after"},  64'(blk_in_ready), 64'd1);
    check_val({tag, "_blk_hold"},     blk_out, c_pre_out);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_in         = 1'b1;
    blk_in         = '0;
    blk_in_valid   = 1'b0;
    scomp_in       = '0;
    scomp_in_valid = 1'b0;
    build_subkeys();
    repeat (3) tick();

    check_val("rst_ready",  64'(blk_in_ready), 64'd1);
    check_val("rst_rvalid", 64'(r_out_valid), 64'd0);
    check_val("rst_r",      64'(r_out), 64'd0);
    check_val("rst_round",  64'(round_idx_out), 64'd0);
    check_val("rst_blkout", blk_out, 64'd0);
    check_val("rst_bvalid", 64'(blk_out_valid), 64'd0);
    rst_in = 1'b0;
    tick();

    // Stray S-box valid while idle.
    scomp_in       = 32'hFFFFFFFF;
    scomp_in_valid = 1'b1;
    tick();
    check_val("idle_stray_ready",  64'(blk_in_ready), 64'd1);
    check_val("idle_stray_rvalid", 64'(r_out_valid), 64'd0);

    // Accept; stray valid stays high through ISSUE.
    blk_in       = c_post_ip;
    blk_in_valid = 1'b1;
    tick();
    blk_in_valid = 1'b0;
    check_val("iss_rvalid", 64'(r_out_valid), 64'd1);
    check_val("iss_r",      64'(r_out), 64'hF0AAF0AA);
    check_val("iss_round",  64'(round_idx_out), 64'd0);
    check_val("iss_ready",  64'(blk_in_ready), 64'd0);
    tick();
    scomp_in_valid = 1'b0;
    check_val("wait_rvalid", 64'(r_out_valid), 64'd0);
    check_val("wait_r_hold", 64'(r_out), 64'hF0AAF0AA);
    check_val("wait_round",  64'(round_idx_out), 64'd0);
    tick();
    check_val("wait2_rvalid", 64'(r_out_valid), 64'd0);

    // Round 1 with the reference S-box word.
    scomp_in       = 32'h5C82B597;
    scomp_in_valid = 1'b1;
    tick();
    scomp_in_valid = 1'b0;
    check_val("r1_rvalid", 64'(r_out_valid), 64'd1);
    check_val("r1_r",      64'(r_out), 64'hEF4A6544);
    check_val("r1_round",  64'(round_idx_out), 64'd1);
    pulse_reset();

    // P permutation: S-box bit 1 lands on output bit 9.
    blk_in       = 64'd0;
    blk_in_valid = 1'b1;
    tick();
    blk_in_valid = 1'b0;
    tick();
    scomp_in       = 32'h80000000;
    scomp_in_valid = 1'b1;
    tick();
    scomp_in_valid = 1'b0;
    check_val("pbit_r", 64'(r_out), 64'h00800000);
    pulse_reset();

    run_block(c_post_ip, -1, "full1");
    run_block(c_post_ip, 7,  "abort7");
    run_block(c_post_ip, -1, "full2");

`ifdef DES_FEISTEL_TIMEOUT_EN
    begin
      int   n;
      logic bv_seen;
      blk_in       = c_post_ip;
      blk_in_valid = 1'b1;
      tick();
      blk_in_valid = 1'b0;
      tick();
      n       = 0;
      bv_seen = 1'b0;
      while (!err_out && n < TIMEOUT_CYC + 20) begin
        tick();
        n++;
        if (blk_out_valid) bv_seen = 1'b1;
      end
      check_val("to_err_seen", 64'(err_out), 64'd1);
      check_val("to_cycles",   64'(n), 64'(TIMEOUT_CYC));
      check_val("to_ready",    64'(blk_in_ready), 64'd1);
      check_val("to_no_bvalid", 64'(bv_seen), 64'd0);
      tick();
      check_val("to_err_pulse", 64'(err_out), 64'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
